// File: rtl/booth_mult_seq.sv
// ---------------------------------------------------------------------------
// booth_mult_seq
// Iterative radix-4 Booth multiplier with valid/ready handshakes on both sides.
// One Booth digit is retired per clock, so a product takes ITER cycles from
// operand acceptance to out_valid. The full 2*WIDTH-bit product is returned.
// Operands are both signed (sgn=1) or both unsigned (sgn=0), per transaction.
//
// Optional build macro:
//   MULT_OVF_EN - adds output ovf, set when the product does not fit in
//                 WIDTH bits of the selected signedness.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   block can accept operands (IDLE only)
//   a          multiplicand, WIDTH bits
//   b          multiplier (Booth-recoded), WIDTH bits
//   sgn        1 = signed operands, 0 = unsigned operands
//   out_valid  product valid
//   out_ready  consumer accepts product
//   p          full product, 2*WIDTH bits
//   ovf        overflow flag (MULT_OVF_EN only)
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for operands; in_ready=1
// BUSY  | one Booth digit per clock, counter runs 0..ITER-1
// DONE  | product held on p with out_valid=1 until out_ready
// ---------------------------------------------------------------------------
module booth_mult_seq #(
    parameter int WIDTH = 16,
    parameter int ITER  = WIDTH / 2 + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sgn,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
`ifdef MULT_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int EW = WIDTH + 2;          // extended operand width
    localparam int MW = WIDTH + 3;          // Booth multiple width (holds +/-2a)
    localparam int AW = 2 * WIDTH + 4;      // accumulator width
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [EW-1:0]        r_a_ext;
    // b_ext with an implicit b_ext[-1]=0 appended at the bottom; shifted right
    // by two each iteration so the current Booth triplet is always bits [2:0].
    logic [EW:0]          r_b_sh;
    logic [AW-1:0]        r_acc;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_p;

    logic                 w_in_ready;
    logic                 w_out_valid;
    logic                 w_accept;
    logic                 w_busy;
    logic                 w_finish;
    logic                 w_last;

    logic [2:0]           w_trip;
    logic [MW-1:0]        w_a_m;
    logic [MW-1:0]        w_a2_m;
    logic [MW-1:0]        w_mult;
    logic [AW-1:0]        w_mult_ext;
    logic [AW-1:0]        w_pp;
    logic [AW-1:0]        w_acc_nxt;
    logic [EW-1:0]        w_a_in_ext;
    logic [EW-1:0]        w_b_in_ext;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_accept    = 1'b0;
        w_busy      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The state register resets to IDLE, but no operand may be taken while
    // reset is still asserted, so in_ready is also qualified by reset_n.
    assign in_ready  = w_in_ready & reset_n;
    assign out_valid = w_out_valid;
    assign p         = r_p;

    // ------------------------------------------------------------------
    // Booth recoding and partial-product selection
    // ------------------------------------------------------------------
    assign w_a_in_ext = {{2{sgn & a[WIDTH-1]}}, a};
    assign w_b_in_ext = {{2{sgn & b[WIDTH-1]}}, b};

    assign w_trip = r_b_sh[2:0];
    assign w_a_m  = {r_a_ext[EW-1], r_a_ext};
    assign w_a2_m = {r_a_ext, 1'b0};

    always_comb begin
        w_mult = '0;
        case (w_trip)
            3'b001, 3'b010: w_mult = w_a_m;
            3'b011:         w_mult = w_a2_m;
            3'b100:         w_mult = -w_a2_m;
            3'b101, 3'b110: w_mult = -w_a_m;
            default:        w_mult = '0;
        endcase
    end

    assign w_mult_ext = {{(AW-MW){w_mult[MW-1]}}, w_mult};
    assign w_pp       = w_mult_ext << {r_cnt, 1'b0};
    assign w_acc_nxt  = r_acc + w_pp;
    assign w_last     = (r_cnt == CW'(ITER - 1));

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_ext <= '0;
            r_b_sh  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_p     <= '0;
        end else if (w_accept) begin
            r_a_ext <= w_a_in_ext;
            r_b_sh  <= {w_b_in_ext, 1'b0};
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (w_busy) begin
            r_acc  <= w_acc_nxt;
            r_b_sh <= r_b_sh >> 2;
            r_cnt  <= r_cnt + CW'(1);
            if (w_finish) begin
                r_p <= w_acc_nxt[2*WIDTH-1:0];
            end
        end
    end

`ifdef MULT_OVF_EN
    logic               r_sgn;
    logic               r_ovf;
    logic               w_ovf_nxt;
    logic [WIDTH:0]     w_hi_s;
    logic [WIDTH-1:0]   w_hi_u;

    // Signed fit needs the upper WIDTH+1 bits to be a pure sign extension.
    assign w_hi_s    = w_acc_nxt[2*WIDTH-1:WIDTH-1];
    assign w_hi_u    = w_acc_nxt[2*WIDTH-1:WIDTH];
    assign w_ovf_nxt = r_sgn ? ~((&w_hi_s) | ~(|w_hi_s)) : (|w_hi_u);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sgn <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_sgn <= sgn;
        end else if (w_finish) begin
            r_ovf <= w_ovf_nxt;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p;
    logic        ovf_s;

    int checks;
    int failures;

`ifdef MULT_OVF_EN
    logic ovf;
    assign ovf_s = ovf;
`else
    assign ovf_s = 1'b0;
`endif

    booth_mult_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sgn       (sgn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
`ifdef MULT_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one transaction: waits for in_ready, accepts, scrambles the
    // inputs after acceptance, waits for out_valid, optionally stalls
    // out_ready for 'hold' cycles, and returns after the consuming edge.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input logic ts,
                          input int hold, output logic [31:0] rp, output logic rovf,
                          output int lat, output bit tmo);
        int n;
        tmo  = 1'b0;
        rp   = '0;
        rovf = 1'b0;
        lat  = 0;
        a = ta; b = tbv; sgn = ts; in_valid = 1'b1;
        out_ready = (hold == 0);
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin tmo = 1'b1; in_valid = 1'b0; return; end
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~ta; b = ~tbv; sgn = ~ts;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!out_valid) begin tmo = 1'b1; return; end
        rp   = p;
        rovf = ovf_s;
        if (hold != 0) begin
            repeat (hold) @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    function automatic logic exp_ovf(input logic [31:0] prod, input logic s);
        if (s) return !((&prod[31:15]) || !(|prod[31:15]));
        else   return |prod[31:16];
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 16'h0; b = 16'h0; sgn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++;
        if (p !== 32'h0) begin failures++; $display("FAIL reset_p got=%h want=00000000", p); end
`ifdef MULT_OVF_EN
        checks++;
        if (ovf_s !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", ovf_s); end
`endif
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] rp; logic rovf; int lat; bit tmo;
        run_op(16'd3, 16'd5, 1'b0, 0, rp, rovf, lat, tmo);
        checks++;
        if (tmo) begin failures++; $display("FAIL basic_timeout got=1 want=0"); end
        checks++;
        if (rp !== 32'h0000000F) begin failures++; $display("FAIL basic_p got=%h want=0000000f", rp); end
        checks++;
        if (lat != 9) begin failures++; $display("FAIL basic_latency got=%0d want=9", lat); end
`ifdef MULT_OVF_EN
        checks++;
        if (rovf !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%b want=0", rovf); end
`endif
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_consume got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vs;
        logic [31:0] vp;
        logic        vo;
    } vec_t;

    task automatic test_extremes();
        vec_t vecs[10];
        logic [31:0] rp; logic rovf; int lat; bit tmo;
        vecs[0] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 1'b0};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b1};
        vecs[2] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b1};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, 1'b0};
        vecs[4] = '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001, 1'b1};
        vecs[5] = '{16'hFFFF, 16'h0005, 1'b1, 32'hFFFFFFFB, 1'b0};
        vecs[6] = '{16'h0000, 16'hFFFF, 1'b0, 32'h00000000, 1'b0};
        vecs[7] = '{16'h00FF, 16'h0100, 1'b0, 32'h0000FF00, 1'b0};
        vecs[8] = '{16'h0100, 16'h0100, 1'b1, 32'h00010000, 1'b1};
        vecs[9] = '{16'h8000, 16'hFFFF, 1'b0, 32'h7FFF8000, 1'b1};
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vs, i % 3, rp, rovf, lat, tmo);
            checks++;
            if (tmo || rp !== vecs[i].vp) begin
                failures++;
                $display("FAIL extreme_p[%0d] got=%h want=%h tmo=%0d", i, rp, vecs[i].vp, tmo);
            end
`ifdef MULT_OVF_EN
            checks++;
            if (rovf !== vecs[i].vo) begin
                failures++;
                $display("FAIL extreme_ovf[%0d] got=%b want=%b", i, rovf, vecs[i].vo);
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        int n; int bad;
        out_ready = 1'b0;
        a = 16'h0012; b = 16'h0034; sgn = 1'b0; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        // A second request is held on the inputs the whole time.
        a = 16'h0101; b = 16'h0202;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (p !== 32'h000003A8) begin failures++; $display("FAIL bp_p got=%h want=000003a8", p); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (p !== 32'h000003A8 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL bp_hold got=%0d bad_cycles want=0", bad); end
`ifdef MULT_OVF_EN
        checks++;
        if (ovf_s !== 1'b0) begin failures++; $display("FAIL bp_ovf got=%b want=0", ovf_s); end
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (p !== 32'h00020402) begin failures++; $display("FAIL bp_second_p got=%h want=00020402", p); end
`ifdef MULT_OVF_EN
        checks++;
        if (ovf_s !== 1'b1) begin failures++; $display("FAIL bp_second_ovf got=%b want=1", ovf_s); end
`endif
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%b want=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rp; logic rovf; int lat; bit tmo; int n;
        out_ready = 1'b1;
        a = 16'h1234; b = 16'h5678; sgn = 1'b0; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || p !== 32'h0 || in_ready !== 1'b0 || ovf_s !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got out_valid=%b p=%h in_ready=%b want 0/00000000/0", out_valid, p, in_ready);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        run_op(16'h1234, 16'h5678, 1'b0, 0, rp, rovf, lat, tmo);
        checks++;
        if (tmo || rp !== 32'h06260060) begin failures++; $display("FAIL reset_after_p got=%h want=06260060", rp); end
`ifdef MULT_OVF_EN
        checks++;
        if (rovf !== 1'b1) begin failures++; $display("FAIL reset_after_ovf got=%b want=1", rovf); end
`endif
        // Reset while the product is parked in DONE.
        out_ready = 1'b0;
        a = 16'h0009; b = 16'h0009; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (p !== 32'h00000051) begin failures++; $display("FAIL done_p got=%h want=00000051", p); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || p !== 32'h0) begin
            failures++;
            $display("FAIL reset_done got out_valid=%b p=%h want 0/00000000", out_valid, p);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rp; logic rovf; int lat; bit tmo;
        run_op(16'h0007, 16'h0009, 1'b0, 0, rp, rovf, lat, tmo);
        checks++;
        if (tmo || rp !== 32'h0000003F) begin failures++; $display("FAIL b2b_first got=%h want=0000003f", rp); end
        run_op(16'hFFF9, 16'h0009, 1'b1, 0, rp, rovf, lat, tmo);
        checks++;
        if (tmo || rp !== 32'hFFFFFFC1) begin failures++; $display("FAIL b2b_second got=%h want=ffffffc1", rp); end
        checks++;
        if (lat != 9) begin failures++; $display("FAIL b2b_latency got=%0d want=9", lat); end
    endtask

    task automatic test_random();
        logic [31:0] rp; logic rovf; int lat; bit tmo;
        logic [15:0] ra; logic [15:0] rb; logic rs;
        logic [31:0] ep;
        int bad_p; int bad_o;
        bad_p = 0; bad_o = 0;
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            if (i % 10 == 0) ra = 16'h8000;
            if (i % 10 == 1) rb = 16'hFFFF;
            if (rs) ep = 32'($signed({{16{ra[15]}}, ra}) * $signed({{16{rb[15]}}, rb}));
            else    ep = {16'h0, ra} * {16'h0, rb};
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            run_op(ra, rb, rs, $urandom_range(0, 3), rp, rovf, lat, tmo);
            if (tmo || rp !== ep) begin
                bad_p++;
                if (bad_p < 5) $display("FAIL random_p a=%h b=%h s=%b got=%h want=%h", ra, rb, rs, rp, ep);
            end
            if (rovf !== exp_ovf(ep, rs)) bad_o++;
        end
        checks++;
        if (bad_p != 0) begin failures++; $display("FAIL random_products got=%0d wrong want=0", bad_p); end
`ifdef MULT_OVF_EN
        checks++;
        if (bad_o != 0) begin failures++; $display("FAIL random_ovf got=%0d wrong want=0", bad_o); end
`endif
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
